// File: rtl/io_input_conditioner.sv
// Per-channel 2-flop sync + debounce; level/pulse outputs registered, level follows raw after 2+DEBOUNCE_CYCLES edges.
// No flow control. Optional toggle latches under `INPUT_TOGGLE_EN (toggle_o tied 0 otherwise).
module io_input_conditioner #(
  parameter int NUM_INPUTS      = 4,
  parameter int CNT_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] raw_i,
  output logic [NUM_INPUTS-1:0] level_o,
  output logic [NUM_INPUTS-1:0] rise_o,
  output logic [NUM_INPUTS-1:0] fall_o,
  output logic [NUM_INPUTS-1:0] toggle_o
);

  localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [NUM_INPUTS-1:0] r_sync1;
  logic [NUM_INPUTS-1:0] r_sync2;
  logic [NUM_INPUTS-1:0] r_level;
  logic [NUM_INPUTS-1:0] r_rise;
  logic [NUM_INPUTS-1:0] r_fall;
  logic [NUM_INPUTS-1:0] w_update;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= raw_i;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_chan
    logic [CNT_WIDTH-1:0] r_cnt;

    // Counter clears on the accepting edge, so it can never pass LP_CNT_LAST.
    assign w_update[g] = (r_sync2[g] != r_level[g]) && (r_cnt == LP_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if ((r_sync2[g] == r_level[g]) || w_update[g]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      r_level <= (r_level & ~w_update) | (r_sync2 & w_update);
      r_rise  <= w_update & r_sync2;
      r_fall  <= w_update & ~r_sync2;
    end
  end

`ifdef INPUT_TOGGLE_EN
  logic [NUM_INPUTS-1:0] r_toggle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_toggle <= '0;
    end else begin
      r_toggle <= r_toggle ^ r_rise;
    end
  end

  assign toggle_o = r_toggle;
`else
  assign toggle_o = '0;
`endif

  assign level_o = r_level;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Randomised and directed stimulus against a sample-window reference model (DEBOUNCE_CYCLES=4).
module tb_io_input_conditioner;

  localparam int N   = 4;
  localparam int DB  = 4;
  localparam int HMAX = 4096;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] raw_i;
  logic [N-1:0] level_o, rise_o, fall_o, toggle_o;

  io_input_conditioner #(
    .NUM_INPUTS(N), .CNT_WIDTH(16), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw_i(raw_i),
    .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o), .toggle_o(toggle_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: raw value present at each edge since the last reset release.
  logic [N-1:0] hist [0:HMAX-1];
  int           n;
  logic [N-1:0] m_level, m_rise, m_fall, m_tog;

  // Observed pulse bookkeeping for directed checks.
  int obs_rise [N];
  int obs_fall [N];
  int first_rise0, first_fall2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: observed %0h, expected %0h", tag, n, obs, exp);
    end
  endtask

  // Synchronised value seen by the debouncer at edge j: raw sampled two edges earlier.
  function automatic logic sync_at(input int ch, input int j);
    if (j - 2 < 1) return 1'b0;
    return hist[j-2][ch];
  endfunction

  task automatic model_clear();
    n = 0;
    m_level = '0; m_rise = '0; m_fall = '0; m_tog = '0;
    for (int i = 0; i < HMAX; i++) hist[i] = '0;
  endtask

  task automatic clear_obs();
    for (int c = 0; c < N; c++) begin
      obs_rise[c] = 0;
      obs_fall[c] = 0;
    end
    first_rise0 = 0;
    first_fall2 = 0;
  endtask

  // A level is accepted once the last DB synchronised samples all disagree with it.
  task automatic model_edge();
    logic [N-1:0] prev_rise;
    logic         upd, s;
    prev_rise = m_rise;
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < N; c++) begin
      upd = 1'b1;
      for (int j = n - DB + 1; j <= n; j++)
        if (sync_at(c, j) == m_level[c]) upd = 1'b0;
      if (upd) begin
        s = sync_at(c, n);
        m_level[c] = s;
        m_rise[c]  = s;
        m_fall[c]  = ~s;
      end
    end
`ifdef INPUT_TOGGLE_EN
    m_tog = m_tog ^ prev_rise;
`else
    m_tog = prev_rise & '0;
`endif
  endtask

  task automatic do_cycle(input logic [N-1:0] r);
    raw_i = r;
    @(posedge clk);
    n++;
    if (n >= HMAX) begin
      $display("FAIL hist_overflow: edge %0d, limit %0d", n, HMAX);
      $fatal(1);
    end
    hist[n] = r;
    model_edge();
    #1;
    chk("level", {28'd0, level_o}, {28'd0, m_level});
    chk("rise", {28'd0, rise_o}, {28'd0, m_rise});
    chk("fall", {28'd0, fall_o}, {28'd0, m_fall});
    chk("toggle", {28'd0, toggle_o}, {28'd0, m_tog});
    for (int c = 0; c < N; c++) begin
      obs_rise[c] += int'(rise_o[c]);
      obs_fall[c] += int'(fall_o[c]);
    end
    if (rise_o[0] && first_rise0 == 0) first_rise0 = n;
    if (fall_o[2] && first_fall2 == 0) first_fall2 = n;
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_level", {28'd0, level_o}, 32'd0);
    chk("rst_rise", {28'd0, rise_o}, 32'd0);
    chk("rst_fall", {28'd0, fall_o}, 32'd0);
    chk("rst_toggle", {28'd0, toggle_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    clear_obs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time expired, limit 2000000");
    $fatal(1);
  end

  initial begin
    int k0;
    logic [N-1:0] r;
    rst_n = 1'b0;
    raw_i = '0;
    model_clear();
    clear_obs();
    #3;
    apply_reset();

    // Clean rise on channel 0.
    for (int i = 0; i < 10; i++) do_cycle(4'b0001);
    chk("clean_rise_edge", first_rise0, 6);
    chk("clean_rise_count", obs_rise[0], 1);
    chk("clean_rise_nofall", obs_fall[0], 0);

    // Reset while channel 0 counts (cnt=2 after the fourth edge), then re-accept.
    apply_reset();
    for (int i = 0; i < 4; i++) do_cycle(4'b0001);
    apply_reset();
    for (int i = 0; i < 10; i++) do_cycle(4'b0001);
    chk("rst_rerise_edge", first_rise0, 6);
    chk("rst_rerise_level", {31'd0, level_o[0]}, 32'd1);

    // Bounce rejection on channel 1.
    apply_reset();
    for (int i = 0; i < 3; i++) do_cycle(4'b0010);
    do_cycle(4'b0000);
    for (int i = 0; i < 3; i++) do_cycle(4'b0010);
    for (int i = 0; i < 10; i++) do_cycle(4'b0000);
    chk("bounce_rise", obs_rise[1], 0);
    chk("bounce_fall", obs_fall[1], 0);

    // Fall on channel 2.
    for (int i = 0; i < 10; i++) do_cycle(4'b0100);
    k0 = n;
    for (int i = 0; i < 10; i++) do_cycle(4'b0000);
    chk("fall_edge", first_fall2 - k0, 6);
    chk("fall_count", obs_fall[2], 1);

    // Three presses on channel 3.
    clear_obs();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 8; i++) do_cycle(4'b1000);
      for (int i = 0; i < 8; i++) do_cycle(4'b0000);
    end
    chk("toggle_presses", obs_rise[3], 3);
`ifdef INPUT_TOGGLE_EN
    chk("toggle_final", {31'd0, toggle_o[3]}, 32'd1);
`else
    chk("toggle_final", {31'd0, toggle_o[3]}, 32'd0);
`endif

    // Channel independence: hold lengths 2, 4, 5, 8.
    clear_obs();
    for (int i = 0; i < 12; i++) begin
      r[0] = (i < 2);
      r[1] = (i < 4);
      r[2] = (i < 5);
      r[3] = (i < 8);
      do_cycle(r);
    end
    chk("indep_ch0", obs_rise[0], 0);
    chk("indep_ch1", obs_rise[1], 1);
    chk("indep_ch2", obs_rise[2], 1);
    chk("indep_ch3", obs_rise[3], 1);

    // Random phases with frequent then rare flips, with a reset in between.
    r = '0;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 3) == 0) r[c] = ~r[c];
      do_cycle(r);
    end
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 7) == 0) r[c] = ~r[c];
      do_cycle(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
